pix_bitplane_tx: RTL
====================

Name: pix_bitplane_tx

Overview:
- Frame source for the pixel-write port of the convolution top (DATA/DATA_VLD/DATA_HSYNC/DATA_SOP/WREADY). This is the transmitting end of the interface the top receives.
- Takes 8-bit pixels in raster order from an upstream byte stream.
- Serialises each pixel into 8 bit-planes, LSB first. Each plane is replicated DW times onto DATA.
- Frames each plane transfer with SOP, HSYNC and WREADY flow control.
- Replaces the behavioural packet generator so that SRAM-load paths can be driven in hardware.

Parameters:
DW, 128, DATA width; each plane drives {DW{pix[bit]}}
GAP_CYC, 5, idle cycles between DATA update and first WREADY sample (min 1)
MAX_PIC, 64, largest legal PIC_SIZE
PSW, 8, width of PIC_SIZE and row/col counters

Ports:
SYS_CLK  in  1  clock, all logic on rising edge
SYS_RST  in  1  asynchronous, active-high reset
START  in  1  one-cycle frame start request
PIC_SIZE  in  PSW  frame edge length N; latched on accepted START
PIX_IN  in  8  upstream pixel byte
PIX_IN_VLD  in  1  upstream byte valid
PIX_IN_RDY  out  1  byte accepted when PIX_IN_VLD&PIX_IN_RDY
WREADY  in  1  downstream can take one plane
DATA  out  DW  replicated bit-plane
DATA_VLD  out  1  one-cycle plane strobe
DATA_HSYNC  out  1  one-cycle end-of-row strobe
DATA_SOP  out  1  one-cycle start-of-frame strobe
BUSY  out  1  frame in progress
DONE  out  1  one-cycle frame complete
ERR  out  1  one-cycle illegal PIC_SIZE on START

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM to IDLE, counters 0. Asserting reset mid-frame abandons the frame; no HSYNC or DONE is issued.
- All outputs are registered. PIX_IN_RDY is the only output decoded directly from state (state==FETCH).
- FSM states: IDLE, SOP, FETCH, GAP, SEND, STRB, HSYNC, FIN.
- IDLE:
  - START with 3<=PIC_SIZE<=MAX_PIC: latch N, set BUSY, go to SOP.
  - START with an illegal size: ERR=1 for the next cycle, remain in IDLE.
- SOP: DATA_SOP=1 for exactly this cycle. Clear row, col and bit counters. Go to FETCH.
- FETCH: PIX_IN_RDY=1; wait here indefinitely. On PIX_IN_VLD, latch the byte, set bit=0, load DATA={DW{byte[0]}}, go to GAP.
- GAP: hold DATA for GAP_CYC cycles, then go to SEND.
- SEND: sample WREADY.
  - WREADY=0: stay in SEND.
  - WREADY=1: go to STRB.
- Receiver contract: WREADY deasserts only after the receiver consumes a DATA_VLD.
- STRB: DATA_VLD=1 for this cycle only; DATA is unchanged.
  - bit<7: bit++, DATA={DW{byte[bit+1]}}, go to GAP.
  - bit==7 and col<N-1: col++, go to FETCH.
  - bit==7 and col==N-1: go to HSYNC.
- HSYNC: DATA_HSYNC=1 for one cycle, col=0.
  - row<N-1: row++, go to FETCH.
  - row==N-1: go to FIN.
- FIN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Throughput with WREADY held high: each plane takes GAP_CYC+2 cycles; each pixel takes 8*(GAP_CYC+2)+1 cycles including FETCH.
- Counts per frame:
  - exactly N*N*8 DATA_VLD pulses;
  - exactly N DATA_HSYNC pulses, each one cycle after the last STRB of its row;
  - exactly 1 DATA_SOP.
- Simultaneous and edge events:
  - START while BUSY is ignored; no ERR, and the latched N is unchanged.
  - PIC_SIZE changing mid-frame has no effect.
  - A START in the same cycle as FIN is ignored; START is accepted from the next cycle.
  - DATA keeps its last plane in IDLE until the next FETCH load.

Decomposition:
- Shared package pix_tx_pkg holds:
  - state encoding localparams;
  - MIN_PIC=3;
  - the bit-index width constant 3.
- The top-level module contains FSM plus counters.
- One natural sub-module: pix_plane_gap_cnt, a loadable down-counter that produces a gap_done pulse. It is reusable for the read-side pacing.

Test Plan:
1. DW=128, N=8, bytes v=i+8j in raster order, WREADY=1, PIX_IN_VLD always 1 -> results:
   - SOP at START+1;
   - 512 DATA_VLD pulses, with DATA all-ones iff v[bit];
   - 8 HSYNC pulses;
   - DONE once;
   - total length 1 + 64*57 + 8 + 1 cycles after SOP.
2. N=3, single frame, pixel 0xA5 -> planes 1,0,1,0,0,1,0,1 (LSB first). Three HSYNC pulses, each following the 24th STRB of its row.
3. WREADY low for 20 cycles at plane 3 of pixel 2 -> design stalls in SEND, DATA stable, no VLD until one cycle after WREADY rises. Frame otherwise identical.
4. START with PIC_SIZE=2, then with PIC_SIZE=MAX_PIC+1 -> ERR pulses once each, BUSY stays 0, no SOP.
5. Second START mid-frame plus PIC_SIZE changed to 4 -> ignored; frame completes with the original N=8 counts.
6. SYS_RST asserted asynchronously mid-GAP of pixel 10 -> all outputs 0 immediately, FSM in IDLE, no DONE. A new START after release gives a clean frame matching scenario 1.

Source files
------------

// File: rtl/pix_tx_pkg.sv
// Shared constants and state encoding for the bit-plane pixel transmitter.
package pix_tx_pkg;

    localparam int unsigned MIN_PIC = 3;
    localparam int unsigned BIT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOP   = 3'd1,
        ST_FETCH = 3'd2,
        ST_GAP   = 3'd3,
        ST_SEND  = 3'd4,
        ST_STRB  = 3'd5,
        ST_HSYNC = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

endpackage

// File: rtl/pix_plane_gap_cnt.sv
// Loadable down-counter; gap_done_o is a registered flag that is high while
// the count sits at zero, so a load of K gives K+1 enabled cycles before done.
module pix_plane_gap_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         gap_done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == '0);
        end
    end

    assign gap_done_o = done_q;

endmodule

// File: rtl/pix_bitplane_tx.sv
// Frame source: serialises raster-order pixel bytes into LSB-first bit-planes,
// each replicated across DATA and paced by a fixed gap plus WREADY handshake.
module pix_bitplane_tx
    import pix_tx_pkg::*;
#(
    parameter int unsigned DW      = 128,
    parameter int unsigned GAP_CYC = 5,
    parameter int unsigned MAX_PIC = 64,
    parameter int unsigned PSW     = 8
) (
    input  logic           SYS_CLK,
    input  logic           SYS_RST,
    input  logic           START,
    input  logic [PSW-1:0] PIC_SIZE,
    input  logic [7:0]     PIX_IN,
    input  logic           PIX_IN_VLD,
    output logic           PIX_IN_RDY,
    input  logic           WREADY,
    output logic [DW-1:0]  DATA,
    output logic           DATA_VLD,
    output logic           DATA_HSYNC,
    output logic           DATA_SOP,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t           state_q, state_d;
    logic [PSW-1:0]   n_q, n_d;
    logic [PSW-1:0]   row_q, row_d;
    logic [PSW-1:0]   col_q, col_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       byte_q, byte_d;
    logic [DW-1:0]    data_q, data_d;
    logic             err_d, err_q;
    logic             sop_q, vld_q, hsync_q, done_q, busy_q;
    logic             gap_load, gap_done, size_ok;

    assign size_ok = (PIC_SIZE >= PSW'(MIN_PIC)) && (PIC_SIZE <= PSW'(MAX_PIC));

    pix_plane_gap_cnt #(.W(GAP_W)) u_gap (
        .clk_i      (SYS_CLK),
        .rst_i      (SYS_RST),
        .load_i     (gap_load),
        .load_val_i (GAP_W'(GAP_CYC - 1)),
        .en_i       (state_q == ST_GAP),
        .gap_done_o (gap_done)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        data_d   = data_q;
        err_d    = 1'b0;
        gap_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (size_ok) begin
                        n_d     = PIC_SIZE;
                        state_d = ST_SOP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SOP: begin
                row_d   = '0;
                col_d   = '0;
                bit_d   = '0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (PIX_IN_VLD) begin
                    byte_d   = PIX_IN;
                    bit_d    = '0;
                    data_d   = {DW{PIX_IN[0]}};
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (WREADY) state_d = ST_STRB;
            end
            ST_STRB: begin
                // next plane is loaded here so DATA settles for the whole gap
                if (bit_q != BIT_W'(7)) begin
                    bit_d    = bit_q + BIT_W'(1);
                    data_d   = {DW{byte_q[bit_q + BIT_W'(1)]}};
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end else if (col_q != n_q - PSW'(1)) begin
                    col_d   = col_q + PSW'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HSYNC;
                end
            end
            ST_HSYNC: begin
                col_d = '0;
                if (row_q != n_q - PSW'(1)) begin
                    row_d   = row_q + PSW'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered decodes of the next state so they align with it.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            sop_q   <= 1'b0;
            vld_q   <= 1'b0;
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            err_q   <= err_d;
            sop_q   <= (state_d == ST_SOP);
            vld_q   <= (state_d == ST_STRB);
            hsync_q <= (state_d == ST_HSYNC);
            done_q  <= (state_d == ST_FIN);
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_FIN);
        end
    end

    assign PIX_IN_RDY = (state_q == ST_FETCH);
    assign DATA       = data_q;
    assign DATA_VLD   = vld_q;
    assign DATA_HSYNC = hsync_q;
    assign DATA_SOP   = sop_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule
